// File: rtl/lockin_lpf_decim.sv
// Lock-in post-mixer low-pass stage: integrate-and-dump over 2^LOG2_N samples, then one-pole IIR.
// I and Q lanes share one frame counter, so both channels always dump on the same sample.
`timescale 1ns/1ps
module lockin_lpf_decim #(
    parameter int DW     = 32,
    parameter int LOG2_N = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] data_sin_i,
    input  logic signed [DW-1:0] data_cos_i,
    input  logic [3:0]           iir_k,
    input  logic                 clear,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out,
    output logic                 out_valid
);
    localparam int ACC_W = DW + LOG2_N;

    logic [LOG2_N-1:0]    cnt_reg;
    logic                 box_valid_reg;
    logic                 seeded_reg;
    logic                 out_valid_reg;
    logic                 frame_done;
    logic signed [DW-1:0] sample [2];
    logic signed [DW-1:0] y_lane [2];

    assign sample[0]  = data_sin_i;
    assign sample[1]  = data_cos_i;
    assign frame_done = in_valid && (cnt_reg == {LOG2_N{1'b1}});

    // Shared frame control; the counter wraps from N-1 to 0 on the dumping sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg       <= '0;
            box_valid_reg <= 1'b0;
            seeded_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (clear) begin
            cnt_reg       <= '0;
            box_valid_reg <= 1'b0;
            seeded_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            box_valid_reg <= frame_done;
            out_valid_reg <= box_valid_reg;
            if (in_valid) begin
                cnt_reg <= cnt_reg + LOG2_N'(1);
            end
            if (box_valid_reg) begin
                seeded_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W-1:0] sum;
            logic signed [DW-1:0]    box_reg;
            logic signed [DW-1:0]    y_reg;
            logic signed [DW:0]      diff;
            logic signed [DW:0]      step;
            logic signed [DW:0]      y_sum;
            logic                    unused_msb;

            assign sum = acc_reg + {{LOG2_N{sample[gi][DW-1]}}, sample[gi]};

            // One extra bit keeps box - y exact; the update lands between y and box, so DW bits suffice.
            assign diff       = {box_reg[DW-1], box_reg} - {y_reg[DW-1], y_reg};
            assign step       = diff >>> iir_k;
            assign y_sum      = {y_reg[DW-1], y_reg} + step;
            assign unused_msb = y_sum[DW];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    acc_reg <= '0;
                    box_reg <= '0;
                end else if (clear) begin
                    acc_reg <= '0;
                end else if (in_valid) begin
                    if (frame_done) begin
                        // Dropping the low LOG2_N bits is an arithmetic shift with floor rounding.
                        box_reg <= sum[ACC_W-1:LOG2_N];
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= sum;
                    end
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    y_reg <= '0;
                end else if (!clear && box_valid_reg) begin
                    if (!seeded_reg || (iir_k == 4'd0)) begin
                        y_reg <= box_reg;
                    end else begin
                        y_reg <= y_sum[DW-1:0];
                    end
                end
            end

            assign y_lane[gi] = y_reg;
        end
    endgenerate

    assign i_out     = y_lane[0];
    assign q_out     = y_lane[1];
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_lockin_lpf_decim.sv
// Scoreboard bench for lockin_lpf_decim with LOG2_N=2 (4-sample frames).
`timescale 1ns/1ps
module tb_lockin_lpf_decim;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] data_sin_i = '0;
    logic signed [DW-1:0] data_cos_i = '0;
    logic [3:0]           iir_k = 4'd0;
    logic                 clear = 1'b0;
    logic signed [DW-1:0] i_out;
    logic signed [DW-1:0] q_out;
    logic                 out_valid;

    lockin_lpf_decim #(.DW(DW), .LOG2_N(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .data_sin_i (data_sin_i),
        .data_cos_i (data_cos_i),
        .iir_k      (iir_k),
        .clear      (clear),
        .i_out      (i_out),
        .q_out      (q_out),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint i;
        longint q;
        int     at_edge;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    int     edge_cnt = 0;

    // Reference model state
    longint m_acc_i = 0, m_acc_q = 0, m_y_i = 0, m_y_q = 0;
    int     m_cnt = 0;
    bit     m_seeded = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic longint iir(input longint y, input longint box, input int k, input bit seeded);
        if (!seeded || k == 0) return box;
        return y + ((box - y) >>> k);
    endfunction

    // One clock of stimulus; the model advances exactly as the sample is presented.
    task automatic step(input bit v, input int s, input int c, input bit clr);
        longint box_i, box_q;
        exp_t e;
        @(negedge clk);
        in_valid   = v;
        data_sin_i = s;
        data_cos_i = c;
        clear      = clr;
        if (clr) begin
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_seeded = 0;
        end else if (v) begin
            m_acc_i += longint'(s);
            m_acc_q += longint'(c);
            if (m_cnt == 3) begin
                box_i = m_acc_i >>> 2;
                box_q = m_acc_q >>> 2;
                m_y_i = iir(m_y_i, box_i, int'(iir_k), m_seeded);
                m_y_q = iir(m_y_q, box_q, int'(iir_k), m_seeded);
                m_seeded = 1;
                e.i = m_y_i; e.q = m_y_q; e.at_edge = edge_cnt + 2;
                sb.push_back(e);
                m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0);
    endtask

    task automatic frame(input int s, input int c, input int gap);
        for (int j = 0; j < 4; j++) begin
            step(1, s, c, 0);
            if (j < 3) idle(gap);
        end
    endtask

    // Output monitor: every pulse must match the oldest expected result at its expected cycle.
    exp_t got_e;
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                got_e = sb.pop_front();
                check("i_out", longint'(i_out), got_e.i);
                check("q_out", longint'(q_out), got_e.q);
                check("latency_edge", edge_cnt, got_e.at_edge);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_i_out", longint'(i_out), 0);
        check("rst_q_out", longint'(q_out), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // 1: plain average, k=0
        iir_k = 4'd0;
        frame(1000, -1000, 0);
        idle(4);
        // 2: floor rounding of negative sums (-5/4 -> -2, 5/4 -> 1)
        step(1, -1, 1, 0); step(1, -1, 1, 0); step(1, -1, 1, 0); step(1, -2, 2, 0);
        idle(4);
        // 3: reseed with zeros, then IIR k=1 towards 1000 back-to-back
        step(0, 0, 0, 1);
        iir_k = 4'd1;
        frame(0, 0, 0);
        for (int f = 0; f < 4; f++) frame(1000, -1000, 0);
        idle(4);
        // 4: idle gaps inside a frame
        iir_k = 4'd0;
        frame(8, -8, 3);
        idle(4);
        // 5: partial frame flushed by clear; outputs hold, next frame reseeds despite k=3
        step(1, 100, 100, 0); step(1, 100, 100, 0);
        step(0, 0, 0, 1);
        #1 check("clear_hold_i", longint'(i_out), 8);
        check("clear_valid_low", longint'(out_valid), 0);
        iir_k = 4'd3;
        frame(8, 16, 0);
        idle(4);
        // 6: extreme inputs do not wrap; async reset mid-frame
        iir_k = 4'd0;
        frame(int'(32'h8000_0000), int'(32'h7fff_ffff), 0);
        idle(3);
        step(1, 100, 100, 0); step(1, 100, 100, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("arst_i_out", longint'(i_out), 0);
        check("arst_q_out", longint'(q_out), 0);
        check("arst_out_valid", longint'(out_valid), 0);
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_seeded = 0; m_y_i = 0; m_y_q = 0;
        @(negedge clk);
        rstn = 1'b1;
        frame(12, -12, 0);
        idle(5);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
